// File: rtl/ddr3_app_req_ctrl.sv
// Single-beat request sequencer in front of the DDR3 app interface; one transaction in flight.
// Optional statistics counters are built when DDR3_REQ_CTRL_STATS_EN is defined.
module ddr3_app_req_ctrl #(
  parameter int unsigned ADDR_W  = 28,
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned MASK_W  = 16,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic              memory_clk,
  input  logic              rst_n,
  input  logic              init_calib_complete_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic [MASK_W-1:0] req_wmask_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  input  logic              cmd_ready_i,
  output logic [2:0]        cmd_o,
  output logic              cmd_en_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [5:0]        app_burst_number_o,
  input  logic              wr_data_rdy_i,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              wr_data_en_o,
  output logic              wr_data_end_o,
  output logic [MASK_W-1:0] wr_data_mask_o,
  input  logic [DATA_W-1:0] rd_data_i,
  input  logic              rd_data_valid_i,
  input  logic              rd_data_end_i,
  output logic              busy_o,
  output logic [15:0]       stat_wr_o,
  output logic [15:0]       stat_rd_o,
  output logic [15:0]       stat_err_o
);

  localparam logic [9:0] TimeoutCnt = 10'(TIMEOUT);
  localparam logic [2:0] CmdWrite   = 3'b000;
  localparam logic [2:0] CmdRead    = 3'b001;

  typedef enum logic [2:0] {
    StIdle,
    StReady,
    StWrCmd,
    StWrData,
    StRdCmd,
    StRdWait,
    StResp
  } state_e;

  state_e state_q, state_d;
  logic [9:0] timer_q, timer_d;
  logic       rsp_valid_d, rsp_err_d;
  logic       accept, capture;

  logic              we_q;
  logic              req_ready_q, cmd_en_q, wr_data_en_q, busy_q;
  logic              rsp_valid_q, rsp_err_q;
  logic [2:0]        cmd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wr_data_q, rsp_rdata_q;
  logic [MASK_W-1:0] wr_data_mask_q;

  // Single-beat transfers: the end flag and the low address bits carry no information.
  logic unused_inputs;
  assign unused_inputs = ^{rd_data_end_i, req_addr_i[2:0]};

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    accept      = 1'b0;
    capture     = 1'b0;
    if (!init_calib_complete_i) begin
      // Calibration loss aborts anything in flight with an error response.
      state_d = StIdle;
      accept  = (state_q == StReady) && req_valid_i;
      if ((state_q inside {StWrCmd, StWrData, StRdCmd, StRdWait}) || accept) begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
      end
    end else begin
      unique case (state_q)
        StIdle:  state_d = StReady;
        StReady: begin
          if (req_valid_i) begin
            accept  = 1'b1;
            state_d = req_we_i ? StWrCmd : StRdCmd;
          end
        end
        StWrCmd: begin
          if (cmd_ready_i) state_d = StWrData;
        end
        StWrData: begin
          if (wr_data_rdy_i) begin
            state_d     = StResp;
            rsp_valid_d = 1'b1;
          end
        end
        StRdCmd: begin
          if (cmd_ready_i) begin
            state_d = StRdWait;
            timer_d = '0;
          end
        end
        StRdWait: begin
          if (timer_q != '1) timer_d = timer_q + 10'd1;
          if (rd_data_valid_i) begin
            capture     = 1'b1;
            state_d     = StResp;
            rsp_valid_d = 1'b1;
          end else if (timer_q == TimeoutCnt) begin
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end
        end
        StResp:  state_d = StReady;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge memory_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      timer_q        <= '0;
      we_q           <= 1'b0;
      req_ready_q    <= 1'b0;
      cmd_en_q       <= 1'b0;
      wr_data_en_q   <= 1'b0;
      busy_q         <= 1'b1;
      rsp_valid_q    <= 1'b0;
      rsp_err_q      <= 1'b0;
      cmd_q          <= CmdWrite;
      addr_q         <= '0;
      wr_data_q      <= '0;
      wr_data_mask_q <= '0;
      rsp_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      // Strobes decode the next state so they line up with the state register.
      req_ready_q  <= (state_d == StReady);
      cmd_en_q     <= (state_d == StWrCmd) || (state_d == StRdCmd);
      wr_data_en_q <= (state_d == StWrData);
      busy_q       <= (state_d != StReady);
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      if (accept) begin
        we_q           <= req_we_i;
        cmd_q          <= req_we_i ? CmdWrite : CmdRead;
        addr_q         <= {req_addr_i[ADDR_W-1:3], 3'b000};
        wr_data_q      <= req_wdata_i;
        wr_data_mask_q <= req_wmask_i;
      end
      if (capture) rsp_rdata_q <= rd_data_i;
    end
  end

  assign req_ready_o        = req_ready_q;
  assign rsp_valid_o        = rsp_valid_q;
  assign rsp_err_o          = rsp_err_q;
  assign rsp_rdata_o        = rsp_rdata_q;
  assign cmd_o              = cmd_q;
  assign cmd_en_o           = cmd_en_q;
  assign addr_o             = addr_q;
  assign app_burst_number_o = 6'd0;
  assign wr_data_o          = wr_data_q;
  assign wr_data_en_o       = wr_data_en_q;
  assign wr_data_end_o      = wr_data_en_q;
  assign wr_data_mask_o     = wr_data_mask_q;
  assign busy_o             = busy_q;

`ifdef DDR3_REQ_CTRL_STATS_EN
  logic [15:0] stat_wr_q, stat_rd_q, stat_err_q;
  logic        ok_wr, ok_rd, bad;

  assign ok_wr = rsp_valid_d && !rsp_err_d && we_q;
  assign ok_rd = rsp_valid_d && !rsp_err_d && !we_q;
  assign bad   = rsp_valid_d && rsp_err_d;

  always_ff @(posedge memory_clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_wr_q  <= '0;
      stat_rd_q  <= '0;
      stat_err_q <= '0;
    end else begin
      if (ok_wr && (stat_wr_q != '1))  stat_wr_q  <= stat_wr_q + 16'd1;
      if (ok_rd && (stat_rd_q != '1))  stat_rd_q  <= stat_rd_q + 16'd1;
      if (bad && (stat_err_q != '1))   stat_err_q <= stat_err_q + 16'd1;
    end
  end

  assign stat_wr_o  = stat_wr_q;
  assign stat_rd_o  = stat_rd_q;
  assign stat_err_o = stat_err_q;
`else
  assign stat_wr_o  = 16'd0;
  assign stat_rd_o  = 16'd0;
  assign stat_err_o = 16'd0;
`endif

endmodule

// File: tb/tb_ddr3_app_req_ctrl.sv
// Self-checking bench for ddr3_app_req_ctrl: vector table of transactions, response scoreboard,
// and hand-written sequences for reset, calibration loss and stray read data.
module tb_ddr3_app_req_ctrl;

  logic         memory_clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         calib = 1'b1;
  logic         req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [27:0]  req_addr = '0;
  logic [127:0] req_wdata = '0;
  logic [15:0]  req_wmask = '0;
  logic         rsp_valid, rsp_err;
  logic [127:0] rsp_rdata;
  logic         cmd_ready = 1'b0, cmd_en;
  logic [2:0]   cmd;
  logic [27:0]  addr;
  logic [5:0]   burst;
  logic         wr_data_rdy = 1'b0, wr_data_en, wr_data_end;
  logic [127:0] wr_data;
  logic [15:0]  wr_data_mask;
  logic [127:0] rd_data = '0;
  logic         rd_data_valid = 1'b0;
  logic         busy;
  logic [15:0]  stat_wr, stat_rd, stat_err;

  ddr3_app_req_ctrl dut (
    .memory_clk            (memory_clk),
    .rst_n                 (rst_n),
    .init_calib_complete_i (calib),
    .req_valid_i           (req_valid),
    .req_ready_o           (req_ready),
    .req_we_i              (req_we),
    .req_addr_i            (req_addr),
    .req_wdata_i           (req_wdata),
    .req_wmask_i           (req_wmask),
    .rsp_valid_o           (rsp_valid),
    .rsp_rdata_o           (rsp_rdata),
    .rsp_err_o             (rsp_err),
    .cmd_ready_i           (cmd_ready),
    .cmd_o                 (cmd),
    .cmd_en_o              (cmd_en),
    .addr_o                (addr),
    .app_burst_number_o    (burst),
    .wr_data_rdy_i         (wr_data_rdy),
    .wr_data_o             (wr_data),
    .wr_data_en_o          (wr_data_en),
    .wr_data_end_o         (wr_data_end),
    .wr_data_mask_o        (wr_data_mask),
    .rd_data_i             (rd_data),
    .rd_data_valid_i       (rd_data_valid),
    .rd_data_end_i         (1'b0),
    .busy_o                (busy),
    .stat_wr_o             (stat_wr),
    .stat_rd_o             (stat_rd),
    .stat_err_o            (stat_err)
  );

  always #5 memory_clk = ~memory_clk;

  int cyc = 0;
  always @(posedge memory_clk) cyc <= cyc + 1;

  typedef struct {
    logic         we;
    logic [27:0]  addr;
    logic [127:0] wdata;
    logic [15:0]  wmask;
    int           cmd_wait;
    int           dat_wait;   // writes: wr_data_rdy wait; reads: RD_WAIT cycle of data, -1 none
    logic [127:0] rdata;
    logic [27:0]  exp_addr;
    logic         exp_err;
    int           exp_lat;    // cycles from request cycle to rsp_valid cycle
  } txn_t;

  typedef struct {
    logic         we;
    logic         err;
    logic [127:0] rdata;
    int           t0;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_errors = 0;
  int exp_wr = 0, exp_rd = 0, exp_er = 0;
  logic [127:0] last_rd = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: pops the scoreboard whenever the DUT emits a response.
  always @(negedge memory_clk) begin
    if (rst_n && rsp_valid) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 128'd1, 128'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_err", {127'd0, rsp_err}, {127'd0, e.err});
        check("rsp_latency", 128'(cyc - e.t0), 128'(e.lat));
        if (!e.err && !e.we) begin
          check("rsp_rdata", rsp_rdata, e.rdata);
          last_rd = e.rdata;
        end
        if (e.err) exp_er++;
        else if (e.we) exp_wr++;
        else exp_rd++;
      end
    end
  end

  // Called at a negedge; returns at the negedge of the first cycle after acceptance.
  task automatic issue_req(input txn_t t);
    int k;
    k = 0;
    while (!req_ready && k < 50) begin
      @(negedge memory_clk);
      k++;
    end
    check("req_ready", {127'd0, req_ready}, 128'd1);
    req_valid = 1'b1;
    req_we    = t.we;
    req_addr  = t.addr;
    req_wdata = t.wdata;
    req_wmask = t.wmask;
    sb.push_back('{we: t.we, err: t.exp_err, rdata: t.rdata, t0: cyc, lat: t.exp_lat});
    @(posedge memory_clk);
    @(negedge memory_clk);
    req_valid = 1'b0;
    check("busy_in_txn", {126'd0, req_ready, busy}, 128'b01);
    check("cmd_en_t1", {127'd0, cmd_en}, 128'd1);
    check("cmd_code", {125'd0, cmd}, t.we ? 128'd0 : 128'd1);
    check("cmd_addr", {100'd0, addr}, {100'd0, t.exp_addr});
  endtask

  task automatic run_txn(input txn_t t);
    int j;
    issue_req(t);
    for (int i = 0; i <= t.cmd_wait; i++) begin
      if (i > 0) check("cmd_en_hold", {127'd0, cmd_en}, 128'd1);
      cmd_ready = (i == t.cmd_wait);
      @(posedge memory_clk);
      @(negedge memory_clk);
    end
    cmd_ready = 1'b0;
    check("cmd_en_drop", {127'd0, cmd_en}, 128'd0);
    if (t.we) begin
      for (int i = 0; i <= t.dat_wait; i++) begin
        check("wr_en_end", {126'd0, wr_data_en, wr_data_end}, 128'b11);
        if (i == 0) begin
          check("wr_data", wr_data, t.wdata);
          check("wr_mask", {112'd0, wr_data_mask}, {112'd0, t.wmask});
        end
        wr_data_rdy = (i == t.dat_wait);
        @(posedge memory_clk);
        @(negedge memory_clk);
        check("wr_no_cmd_en", {127'd0, cmd_en}, 128'd0);
      end
      wr_data_rdy = 1'b0;
      check("wr_en_drop", {127'd0, wr_data_en}, 128'd0);
    end else begin
      for (j = 0; j < 1100; j++) begin
        if (rsp_valid) break;
        rd_data_valid = (j == t.dat_wait);
        rd_data       = t.rdata;
        @(posedge memory_clk);
        @(negedge memory_clk);
      end
      rd_data_valid = 1'b0;
      if (j == 1100) check("rd_rsp_bound", 128'd0, 128'd1);
    end
  endtask

  txn_t vecs[6];
  txn_t t;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 28'h0000123, {16{8'hA5}}, 16'h0000, 0, 0, '0, 28'h0000120, 1'b0, 3};
    vecs[1] = '{1'b0, 28'h0000040, '0, 16'h0000, 5, 6, 128'h1234, 28'h0000040, 1'b0, 14};
    vecs[2] = '{1'b1, 28'hFFFFFFF, {4{32'hDEADBEEF}}, 16'h00F0, 2, 3, '0, 28'hFFFFFF8, 1'b0, 8};
    vecs[3] = '{1'b0, 28'h0ABCDE7, '0, 16'h0000, 0, 0, {8{16'hCAFE}}, 28'h0ABCDE0, 1'b0, 3};
    vecs[4] = '{1'b0, 28'h0000100, '0, 16'h0000, 0, -1, 128'h77, 28'h0000100, 1'b1, 1026};
    vecs[5] = '{1'b1, 28'h0000008, {2{64'h0123456789ABCDEF}}, 16'hFFFF, 0, 0, '0, 28'h0000008,
                1'b0, 3};

    // Reset held with calibration already complete.
    repeat (3) @(negedge memory_clk);
    check("rst_outputs", {122'd0, req_ready, cmd_en, wr_data_en, rsp_valid, busy, rsp_err},
          128'b000010);
    check("rst_addr_cmd", {97'd0, addr, cmd}, 128'd0);
    check("rst_data", wr_data | rsp_rdata | {112'd0, wr_data_mask} | {122'd0, burst}, 128'd0);
    rst_n = 1'b1;
    @(posedge memory_clk);
    @(negedge memory_clk);
    check("ready_after_rst", {126'd0, req_ready, busy}, 128'b10);

    for (int v = 0; v < 6; v++) run_txn(vecs[v]);

    // Stray read data in READY is ignored and leaves the held read data alone.
    while (!req_ready) @(negedge memory_clk);
    rd_data_valid = 1'b1;
    rd_data       = 128'hBAD;
    @(posedge memory_clk);
    @(negedge memory_clk);
    rd_data_valid = 1'b0;
    check("stray_rd_no_rsp", {127'd0, rsp_valid}, 128'd0);
    check("rdata_held", rsp_rdata, last_rd);

    // Calibration loss while waiting on write data.
    t = '{1'b1, 28'h0000200, 128'h55, 16'h0001, 0, 0, '0, 28'h0000200, 1'b1, 3};
    issue_req(t);
    cmd_ready = 1'b1;
    @(posedge memory_clk);
    @(negedge memory_clk);
    cmd_ready = 1'b0;
    check("calib_wr_en", {127'd0, wr_data_en}, 128'd1);
    calib = 1'b0;
    @(posedge memory_clk);
    @(negedge memory_clk);
    check("calib_wr_drop", {126'd0, wr_data_en, wr_data_end}, 128'd0);
    repeat (3) begin
      check("calib_not_ready", {126'd0, req_ready, busy}, 128'b01);
      @(posedge memory_clk);
      @(negedge memory_clk);
    end
    calib = 1'b1;
    @(posedge memory_clk);
    @(negedge memory_clk);
    check("calib_back_ready", {127'd0, req_ready}, 128'd1);

`ifdef DDR3_REQ_CTRL_STATS_EN
    check("stat_wr", {112'd0, stat_wr}, 128'(exp_wr));
    check("stat_rd", {112'd0, stat_rd}, 128'(exp_rd));
    check("stat_err", {112'd0, stat_err}, 128'(exp_er));
`else
    check("stat_zero", {80'd0, stat_wr, stat_rd, stat_err}, 128'd0);
`endif

    // Reset in the middle of a read: no response, immediate return to reset values.
    t = '{1'b0, 28'h0000300, '0, 16'h0000, 0, -1, '0, 28'h0000300, 1'b0, 0};
    issue_req(t);
    cmd_ready = 1'b1;
    @(posedge memory_clk);
    @(negedge memory_clk);
    cmd_ready = 1'b0;
    @(posedge memory_clk);
    @(negedge memory_clk);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("mid_rst_outputs", {124'd0, req_ready, cmd_en, rsp_valid, busy}, 128'b0001);
    check("mid_rst_rdata", rsp_rdata | {100'd0, addr}, 128'd0);
    check("mid_rst_stats", {80'd0, stat_wr, stat_rd, stat_err}, 128'd0);
    @(negedge memory_clk);
    rst_n = 1'b1;
    repeat (5) @(negedge memory_clk);
    check("ready_after_mid_rst", {127'd0, req_ready}, 128'd1);
    check("sb_empty", 128'(sb.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
